// File: rtl/traffic_signal_monitor.sv
// traffic_signal_monitor: passive lamp-bus checker latching the first conflict, code, sequence or dwell fault.
// Define TSM_FAULT_COUNT_EN to build the saturating fault event counter behind fault_count.
module traffic_signal_monitor #(
   parameter int MIN_YELLOW = 5,
   parameter int MAX_DWELL  = 64,
   parameter int DW         = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] t1,
   input  logic [1:0] t2,
   input  logic       t1_walk,
   input  logic       t2_walk,
   input  logic       buzzer,
   input  logic       clear_fault,
   output logic [2:0] phase,
   output logic       phase_change,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [7:0] fault_count
);
   localparam logic [1:0] L_G = 2'd0, L_Y = 2'd1, L_R = 2'd2, L_X = 2'd3;
   localparam logic [2:0] P_INV = 3'd0, P_G1 = 3'd1, P_Y1 = 3'd2, P_WALK = 3'd3,
                          P_BUZ = 3'd4, P_G2 = 3'd5, P_Y2 = 3'd6, P_AR = 3'd7;
   localparam logic [DW-1:0] MIN_Y = DW'(MIN_YELLOW);
   localparam logic [DW-1:0] MAX_D = DW'(MAX_DWELL);

   logic [2:0]    cur, succ, code;
   logic [5:0]    pat;
   logic [DW-1:0] dwell, dwell_nxt;
   logic          prev_valid, pre, pre_nxt, change, legal, det;
   logic          c_conf, c_bad, c_walk, c_buz, c_seq, c_short, c_stuck;

   // phase register doubles as the previous-sample phase for transition checks
   assign pat = {t1, t2, t1_walk, buzzer};

   always_comb begin
      cur = (t1_walk != t2_walk)               ? P_INV  :
            pat == {L_G, L_R, 1'b0, 1'b0}      ? P_G1   :
            pat == {L_Y, L_R, 1'b0, 1'b0}      ? P_Y1   :
            pat == {L_R, L_R, 1'b1, 1'b0}      ? P_WALK :
            pat == {L_R, L_R, 1'b1, 1'b1}      ? P_BUZ  :
            pat == {L_R, L_G, 1'b0, 1'b0}      ? P_G2   :
            pat == {L_R, L_Y, 1'b0, 1'b0}      ? P_Y2   :
            pat == {L_R, L_R, 1'b0, 1'b0}      ? P_AR   : P_INV;
      succ = phase == P_G1   ? P_Y1   :
             phase == P_Y1   ? P_WALK :
             phase == P_WALK ? P_BUZ  :
             phase == P_BUZ  ? P_G2   :
             phase == P_G2   ? P_Y2   :
             phase == P_Y2   ? P_G1   : P_INV;
   end

   assign change    = cur != phase;
   assign dwell_nxt = change ? DW'(1) : (&dwell ? dwell : dwell + DW'(1));
   assign pre_nxt   = (cur == P_G2) && (change ? (phase != P_BUZ) : pre);
   assign legal     = (cur == P_AR) || (cur == P_G2) || (phase == P_AR) ||
                      (phase == P_G2 && pre) || (cur == succ);

   assign c_conf  = (t1 != L_R) && (t2 != L_R);
   assign c_bad   = (t1 == L_X) || (t2 == L_X);
   assign c_walk  = ((t1_walk | t2_walk) && (t1 != L_R || t2 != L_R)) || (t1_walk != t2_walk);
   assign c_buz   = buzzer && !(t1_walk && t2_walk);
   assign c_seq   = prev_valid && change && (cur != P_INV) && !legal;
   assign c_short = change && dwell < MIN_Y &&
                    ((phase == P_Y1 && cur == P_WALK) || (phase == P_Y2 && cur == P_G1));
   // a preempted G2 and all-red may be held indefinitely
   assign c_stuck = !change && dwell_nxt == MAX_D && cur != P_INV && cur != P_AR &&
                    !(cur == P_G2 && pre_nxt);

   assign code = c_conf  ? 3'd1 :
                 c_bad   ? 3'd2 :
                 c_walk  ? 3'd3 :
                 c_buz   ? 3'd4 :
                 c_seq   ? 3'd5 :
                 c_short ? 3'd6 :
                 c_stuck ? 3'd7 : 3'd0;
   assign det = code != 3'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase        <= P_INV;
         phase_change <= 1'b0;
         prev_valid   <= 1'b0;
         pre          <= 1'b0;
         dwell        <= '0;
         fault        <= 1'b0;
         fault_code   <= 3'd0;
      end else begin
         phase        <= cur;
         phase_change <= change;
         prev_valid   <= 1'b1;
         pre          <= pre_nxt;
         dwell        <= dwell_nxt;
         if (clear_fault) begin
            fault      <= det;
            fault_code <= code;
         end else if (!fault && det) begin
            fault      <= 1'b1;
            fault_code <= code;
         end
      end
   end

`ifdef TSM_FAULT_COUNT_EN
   logic [7:0] fcnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fcnt <= 8'd0;
      else if (det && fcnt != 8'hff)
         fcnt <= fcnt + 8'd1;
   end

   assign fault_count = fcnt;
`else
   assign fault_count = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// tb_traffic_signal_monitor: directed vectors for traffic_signal_monitor with hand-computed expectations.
module tb_traffic_signal_monitor;
   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] t1, t2;
   logic       t1_walk, t2_walk, buzzer, clear_fault;
   logic [2:0] phase, fault_code;
   logic       phase_change, fault;
   logic [7:0] fault_count;

   int n_vec = 0, n_miss = 0, pulses = 0;
   logic saw_fault = 1'b0;

   traffic_signal_monitor dut (
      .clk(clk), .reset(reset), .t1(t1), .t2(t2), .t1_walk(t1_walk), .t2_walk(t2_walk),
      .buzzer(buzzer), .clear_fault(clear_fault), .phase(phase), .phase_change(phase_change),
      .fault(fault), .fault_code(fault_code), .fault_count(fault_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // hold one input pattern for n cycles; clear_fault only lasts the first cycle
   task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic w1, input logic w2,
                        input logic bz, input int n);
      for (int i = 0; i < n; i++) begin
         t1 = a; t2 = b; t1_walk = w1; t2_walk = w2; buzzer = bz;
         @(posedge clk);
         #1;
         clear_fault = 1'b0;
         if (fault) saw_fault = 1'b1;
         if (phase_change) pulses++;
      end
   endtask

   task automatic seg(input int ph, input int n);
      case (ph)
         1: drive(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, n);
         2: drive(2'd1, 2'd2, 1'b0, 1'b0, 1'b0, n);
         3: drive(2'd2, 2'd2, 1'b1, 1'b1, 1'b0, n);
         4: drive(2'd2, 2'd2, 1'b1, 1'b1, 1'b1, n);
         5: drive(2'd2, 2'd0, 1'b0, 1'b0, 1'b0, n);
         6: drive(2'd2, 2'd1, 1'b0, 1'b0, 1'b0, n);
         default: drive(2'd2, 2'd2, 1'b0, 1'b0, 1'b0, n);
      endcase
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_phase"}, phase, 0);
      chk({tag, "_pchg"}, phase_change, 0);
      chk({tag, "_fault"}, fault, 0);
      chk({tag, "_code"}, fault_code, 0);
      chk({tag, "_count"}, fault_count, 0);
   endtask

   initial begin
      reset = 1'b1; clear_fault = 1'b0;
      t1 = 2'd0; t2 = 2'd2; t1_walk = 1'b0; t2_walk = 1'b0; buzzer = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      reset = 1'b0;

      // two full normal cycles
      for (int k = 0; k < 2; k++) begin
         seg(1, 30); chk("loop_g1", phase, 1);
         seg(2, 5);  chk("loop_y1", phase, 2);
         seg(3, 20); chk("loop_walk", phase, 3);
         seg(4, 5);  chk("loop_buz", phase, 4);
         seg(5, 30); chk("loop_g2", phase, 5);
         seg(6, 5);  chk("loop_y2", phase, 6);
      end
      chk("loop_nofault", saw_fault, 0);
      chk("loop_pulses", pulses, 12);

      // lamp conflict, then sticky across legal patterns
      drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1);
      chk("conf_fault", fault, 1);
      chk("conf_code", fault_code, 1);
      chk("conf_phase", phase, 0);
      seg(1, 5);
      chk("sticky_fault", fault, 1);
      chk("sticky_code", fault_code, 1);
      clear_fault = 1'b1; seg(1, 1);
      chk("clr_fault", fault, 0);
      chk("clr_code", fault_code, 0);

      // short yellow into WALK
      seg(1, 3); seg(2, 3); seg(3, 1);
      chk("short_fault", fault, 1);
      chk("short_code", fault_code, 6);
      clear_fault = 1'b1; seg(3, 1);
      chk("clr2_fault", fault, 0);

      // short yellow into all-red is legal
      saw_fault = 1'b0;
      seg(7, 2); seg(1, 5); seg(2, 3); seg(7, 2);
      chk("y1_ar_nofault", saw_fault, 0);

      // preemption G1 -> G2 -> G1, then long all-red
      seg(1, 10); seg(5, 10);
      chk("pre_phase", phase, 5);
      seg(1, 5);
      chk("pre_nofault", saw_fault, 0);
      seg(7, 200);
      chk("ar_nofault", saw_fault, 0);
      chk("ar_phase", phase, 7);

      // bad code outranks walk-on-green
      drive(2'd3, 2'd2, 1'b1, 1'b0, 1'b0, 1);
      chk("bad_fault", fault, 1);
      chk("bad_code", fault_code, 2);
      clear_fault = 1'b1; seg(7, 1);
      chk("clr3_fault", fault, 0);
      chk("clr3_code", fault_code, 0);
      clear_fault = 1'b1; drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1);
      chk("clrwin_fault", fault, 1);
      chk("clrwin_code", fault_code, 1);

      drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 300);
`ifdef TSM_FAULT_COUNT_EN
      chk("count_sat", fault_count, 255);
`else
      chk("count_off", fault_count, 0);
`endif

      // asynchronous reset mid-operation
      #2 reset = 1'b1;
      #1;
      chk_zero("midreset");
      seg(6, 0);
      t1 = 2'd2; t2 = 2'd1;
      @(posedge clk);
      #1 reset = 1'b0;
      saw_fault = 1'b0; pulses = 0;
      seg(6, 1);
      chk("rst_first_pchg", pulses, 1);
      seg(6, 4);
      chk("rst_phase", phase, 6);
      chk("rst_nofault", saw_fault, 0);

      // dwell limit in G1
      seg(1, 63);
      chk("stuck_before", fault, 0);
      seg(1, 1);
      chk("stuck_fault", fault, 1);
      chk("stuck_code", fault_code, 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
